video_position_tracker: RTL and testbench

Streaming tap on the Avalon-ST video path, located directly upstream of the 17-bit position PIO input port. It watches each RGB565 video frame and records the bounding box of pixels that match a colour threshold (a red marker). At end of frame it publishes the box centre as a packed 17-bit position `{x[8:0], y[7:0]}` to drive that PIO's `in_port`. Video passes through unchanged, with one bubble cycle per frame.

---
 rtl/video_position_tracker.sv | 117 +++++++++++
 tb/tb_video_position_tracker.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_position_tracker.sv
// video_position_tracker: Avalon-ST RGB565 tap that tracks the bounding box of red pixels and publishes its centre per frame
//   clk, reset_n          : clock, synchronous active-low reset
//   in_*                  : video sink (data, valid, startofpacket, endofpacket, ready)
//   out_*                 : video source, combinational copy of the sink, held off during DONE
//   position              : {x[8:0], y[7:0]} centre of the last good frame, 17'h1FFFF = no match
//   pos_valid             : one-cycle pulse when position is written
//   frame_error           : last video packet had the wrong pixel count
module video_position_tracker #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int R_MIN  = 24,
  parameter int G_MAX  = 24,
  parameter int B_MAX  = 12
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  input  logic        in_startofpacket,
  input  logic        in_endofpacket,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  output logic        out_startofpacket,
  output logic        out_endofpacket,
  input  logic        out_ready,
  output logic [16:0] position,
  output logic        pos_valid,
  output logic        frame_error
);
  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int CW = $clog2(TOTAL + 2);
  typedef enum logic [1:0] {IDLE, PIXELS, SKIP, DONE} state_t;
  state_t state, state_nx;
  logic [8:0] x, min_x, max_x;
  logic [7:0] y, min_y, max_y;
  logic [CW-1:0] pix_cnt;
  logic found, accept, hdr, video_hdr, pixel, match, in_frame, wrap;
  logic [9:0] sum_x;
  logic [8:0] sum_y;
  assign in_ready = out_ready & (state != DONE);
  assign out_valid = in_valid & (state != DONE);
  assign out_data = in_data;
  assign out_startofpacket = in_startofpacket;
  assign out_endofpacket = in_endofpacket;
  assign accept = in_valid & in_ready;
  // any sop beat is a header, whatever state it interrupts
  assign hdr = accept & in_startofpacket;
  assign video_hdr = hdr & (in_data[3:0] == 4'd0);
  assign pixel = accept & ~in_startofpacket & (state == PIXELS);
  assign match = (int'(in_data[15:11]) >= R_MIN) & (int'(in_data[10:5]) <= G_MAX) & (int'(in_data[4:0]) <= B_MAX);
  assign in_frame = pix_cnt < CW'(TOTAL);
  assign wrap = x == 9'(WIDTH - 1);
  assign sum_x = {1'b0, min_x} + {1'b0, max_x};
  assign sum_y = {1'b0, min_y} + {1'b0, max_y};
  always_comb begin
    state_nx = state;
    if (hdr)
      state_nx = in_endofpacket ? IDLE : (video_hdr ? PIXELS : SKIP);
    else if (accept & in_endofpacket)
      state_nx = (state == PIXELS) ? DONE : IDLE;
    else if (state == DONE)
      state_nx = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      pix_cnt     <= '0;
      min_x       <= '0;
      max_x       <= '0;
      min_y       <= '0;
      max_y       <= '0;
      found       <= 1'b0;
      position    <= '1;
      pos_valid   <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state     <= state_nx;
      pos_valid <= 1'b0;
      if (video_hdr) begin
        x       <= '0;
        y       <= '0;
        pix_cnt <= '0;
        min_x   <= '0;
        max_x   <= '0;
        min_y   <= '0;
        max_y   <= '0;
        found   <= 1'b0;
      end else if (pixel) begin
        // beats past the nominal frame size only count towards the error check
        if (in_frame && match) begin
          min_x <= (!found || x < min_x) ? x : min_x;
          max_x <= (!found || x > max_x) ? x : max_x;
          min_y <= (!found || y < min_y) ? y : min_y;
          max_y <= (!found || y > max_y) ? y : max_y;
          found <= 1'b1;
        end
        x <= wrap ? 9'd0 : x + 9'd1;
        if (wrap)
          y <= y + 8'd1;
        if (pix_cnt != CW'(TOTAL + 1))
          pix_cnt <= pix_cnt + CW'(1);
      end
      if (state == DONE) begin
        if (pix_cnt == CW'(TOTAL)) begin
          frame_error <= 1'b0;
          pos_valid   <= 1'b1;
          position    <= found ? {sum_x[9:1], sum_y[8:1]} : '1;
        end else begin
          frame_error <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_video_position_tracker.sv
// tb_video_position_tracker: directed bench for video_position_tracker on a reduced 40x30 frame
module tb_video_position_tracker;
  localparam int W = 40;
  localparam int H = 30;
  localparam int N = W * H;
  localparam logic [15:0] RED = 16'hF800;
  logic clk = 0, reset_n = 0;
  logic [15:0] in_data = 0;
  logic in_valid = 0, in_startofpacket = 0, in_endofpacket = 0, in_ready;
  logic [15:0] out_data;
  logic out_valid, out_startofpacket, out_endofpacket;
  logic out_ready = 1;
  logic [16:0] position;
  logic pos_valid, frame_error;
  int checks = 0, failures = 0, pulses = 0, ir_low = 0, p0 = 0;
  int rx0 = 0, rx1 = -1, ry0 = 0, ry1 = -1, sp_idx = -1;
  logic [15:0] rect_col = RED, sp_col = 0;
  bit gaps = 0;
  logic [2:0] pv_pat;
  logic ir_done, ov_done, err_cap;
  logic [16:0] pos_cap;

  always #5 clk = ~clk;

  video_position_tracker #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_startofpacket(in_startofpacket),
    .in_endofpacket(in_endofpacket), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_startofpacket(out_startofpacket),
    .out_endofpacket(out_endofpacket), .out_ready(out_ready),
    .position(position), .pos_valid(pos_valid), .frame_error(frame_error)
  );

  always @(negedge clk) if (pos_valid) pulses++;

  function automatic logic [15:0] pix_col(input int i);
    int px = i % W;
    int py = i / W;
    if (i == sp_idx) return sp_col;
    return (px >= rx0 && px <= rx1 && py >= ry0 && py <= ry1) ? rect_col : 16'h0000;
  endfunction

  task automatic set_rect(input int ax0, input int ax1, input int ay0, input int ay1);
    rx0 = ax0; rx1 = ax1; ry0 = ay0; ry1 = ay1;
  endtask

  task automatic beat(input logic [15:0] d, input logic s, input logic e);
    int k;
    logic acc;
    if (gaps) repeat ($urandom_range(0, 2)) begin
      in_valid = 0;
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_data = d; in_startofpacket = s; in_endofpacket = e; in_valid = 1;
    acc = 0; k = 0;
    while (!acc && k < 100) begin
      out_ready = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      acc = in_ready;
      if (out_ready && !in_ready) ir_low++;
      checks++;
      if (out_valid !== 1'b1 || out_data !== d || out_startofpacket !== s || out_endofpacket !== e) begin
        failures++;
        $display("FAIL passthru: got v=%b d=%h sop=%b eop=%b, need v=1 d=%h sop=%b eop=%b",
                 out_valid, out_data, out_startofpacket, out_endofpacket, d, s, e);
      end
      @(posedge clk); #1;
      k++;
    end
    if (!acc) begin
      checks++; failures++;
      $display("FAIL beat_timeout: got in_ready=0 for 100 cycles, need acceptance");
    end
    in_valid = 0; in_startofpacket = 0; in_endofpacket = 0;
  endtask

  task automatic send(input logic [15:0] hdr, input int npix, input bit eop);
    beat(hdr, 1'b1, eop && npix == 0);
    for (int i = 0; i < npix; i++) beat(pix_col(i), 1'b0, eop && i == npix - 1);
  endtask

  task automatic capture;
    out_ready = 1; in_valid = 1; in_data = 16'h1234;
    @(negedge clk);
    pv_pat[0] = pos_valid; ir_done = in_ready; ov_done = out_valid;
    in_valid = 0;
    @(negedge clk);
    pv_pat[1] = pos_valid; pos_cap = position; err_cap = frame_error;
    @(negedge clk);
    pv_pat[2] = pos_valid;
    #1;
  endtask

  task automatic test_reset;
    reset_n = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (position !== 17'h1FFFF) begin failures++; $display("FAIL reset_pos: got %h need 1ffff", position); end
    checks++; if (pos_valid !== 1'b0) begin failures++; $display("FAIL reset_pv: got %b need 0", pos_valid); end
    checks++; if (frame_error !== 1'b0) begin failures++; $display("FAIL reset_err: got %b need 0", frame_error); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b need 1", in_ready); end
    reset_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_pixel;
    set_rect(30, 30, 20, 20);
    ir_low = 0; p0 = pulses;
    send(16'h0000, N, 1);
    capture;
    checks++; if (pv_pat !== 3'b010) begin failures++; $display("FAIL single_pulse: got %b need 010", pv_pat); end
    checks++; if (ir_done !== 1'b0) begin failures++; $display("FAIL single_done_ready: got %b need 0", ir_done); end
    checks++; if (ov_done !== 1'b0) begin failures++; $display("FAIL single_done_valid: got %b need 0", ov_done); end
    checks++; if (pos_cap !== 17'h01E14) begin failures++; $display("FAIL single_pos: got %h need 01e14", pos_cap); end
    checks++; if (err_cap !== 1'b0) begin failures++; $display("FAIL single_err: got %b need 0", err_cap); end
    checks++; if (pulses - p0 !== 1) begin failures++; $display("FAIL single_count: got %0d need 1", pulses - p0); end
    checks++; if (ir_low !== 0) begin failures++; $display("FAIL single_stall: got %0d need 0", ir_low); end
  endtask

  task automatic test_rectangle;
    set_rect(10, 19, 5, 12);
    send(16'h0000, N, 1);
    capture;
    checks++; if (pos_cap !== 17'h00E08) begin failures++; $display("FAIL rect_pos: got %h need 00e08", pos_cap); end
    checks++; if (pv_pat !== 3'b010) begin failures++; $display("FAIL rect_pulse: got %b need 010", pv_pat); end
    gaps = 1; ir_low = 0;
    send(16'h0000, N, 1);
    capture;
    gaps = 0;
    checks++; if (pos_cap !== 17'h00E08) begin failures++; $display("FAIL rect_gap_pos: got %h need 00e08", pos_cap); end
    checks++; if (pv_pat !== 3'b010) begin failures++; $display("FAIL rect_gap_pulse: got %b need 010", pv_pat); end
    checks++; if (ir_low !== 0) begin failures++; $display("FAIL rect_gap_stall: got %0d need 0", ir_low); end
    checks++; if (ir_done !== 1'b0) begin failures++; $display("FAIL rect_gap_done_ready: got %b need 0", ir_done); end
  endtask

  task automatic test_no_match;
    set_rect(0, -1, 0, -1);
    send(16'h0000, N, 1);
    capture;
    checks++; if (pos_cap !== 17'h1FFFF) begin failures++; $display("FAIL nomatch_pos: got %h need 1ffff", pos_cap); end
    checks++; if (pv_pat !== 3'b010) begin failures++; $display("FAIL nomatch_pulse: got %b need 010", pv_pat); end
  endtask

  task automatic test_threshold;
    set_rect(8, 8, 8, 8);
    rect_col = {5'd23, 6'd0, 5'd0};
    sp_idx = 207; sp_col = {5'd31, 6'd25, 5'd0};
    send(16'h0000, N, 1);
    capture;
    checks++; if (pos_cap !== 17'h1FFFF) begin failures++; $display("FAIL thresh_miss_pos: got %h need 1ffff", pos_cap); end
    set_rect(39, 39, 29, 29);
    rect_col = RED;
    sp_idx = 0; sp_col = {5'd24, 6'd24, 5'd12};
    send(16'h0000, N, 1);
    capture;
    sp_idx = -1;
    checks++; if (pos_cap !== 17'h0130E) begin failures++; $display("FAIL thresh_corner_pos: got %h need 0130e", pos_cap); end
    checks++; if (pv_pat !== 3'b010) begin failures++; $display("FAIL thresh_corner_pulse: got %b need 010", pv_pat); end
  endtask

  task automatic test_bad_packets;
    set_rect(30, 30, 20, 20);
    p0 = pulses;
    send(16'h000F, 8, 1);
    capture;
    checks++; if (pulses - p0 !== 0) begin failures++; $display("FAIL ctrl_count: got %0d need 0", pulses - p0); end
    checks++; if (pos_cap !== 17'h0130E) begin failures++; $display("FAIL ctrl_pos: got %h need 0130e", pos_cap); end
    checks++; if (err_cap !== 1'b0) begin failures++; $display("FAIL ctrl_err: got %b need 0", err_cap); end
    send(16'h0000, 1000, 1);
    capture;
    checks++; if (pv_pat !== 3'b000) begin failures++; $display("FAIL short_pulse: got %b need 000", pv_pat); end
    checks++; if (err_cap !== 1'b1) begin failures++; $display("FAIL short_err: got %b need 1", err_cap); end
    checks++; if (pos_cap !== 17'h0130E) begin failures++; $display("FAIL short_pos: got %h need 0130e", pos_cap); end
    send(16'h0000, N + 1, 1);
    capture;
    checks++; if (pv_pat !== 3'b000) begin failures++; $display("FAIL long_pulse: got %b need 000", pv_pat); end
    checks++; if (err_cap !== 1'b1) begin failures++; $display("FAIL long_err: got %b need 1", err_cap); end
    send(16'h0000, N, 1);
    capture;
    checks++; if (err_cap !== 1'b0) begin failures++; $display("FAIL recover_err: got %b need 0", err_cap); end
    checks++; if (pos_cap !== 17'h01E14) begin failures++; $display("FAIL recover_pos: got %h need 01e14", pos_cap); end
  endtask

  task automatic test_reset_interrupt;
    set_rect(10, 19, 5, 12);
    send(16'h0000, 400, 0);
    reset_n = 0;
    @(posedge clk); #1;
    reset_n = 1;
    p0 = pulses;
    for (int i = 400; i < N; i++) beat(pix_col(i), 1'b0, i == N - 1);
    capture;
    checks++; if (pulses - p0 !== 0) begin failures++; $display("FAIL rstint_count: got %0d need 0", pulses - p0); end
    checks++; if (pos_cap !== 17'h1FFFF) begin failures++; $display("FAIL rstint_pos: got %h need 1ffff", pos_cap); end
    checks++; if (err_cap !== 1'b0) begin failures++; $display("FAIL rstint_err: got %b need 0", err_cap); end
    send(16'h0000, N, 1);
    capture;
    checks++; if (pos_cap !== 17'h00E08) begin failures++; $display("FAIL rstint_next_pos: got %h need 00e08", pos_cap); end
    checks++; if (pv_pat !== 3'b010) begin failures++; $display("FAIL rstint_next_pulse: got %b need 010", pv_pat); end
  endtask

  task automatic test_sop_midframe;
    set_rect(2, 3, 2, 3);
    send(16'h0000, 500, 0);
    set_rect(30, 30, 20, 20);
    p0 = pulses;
    send(16'h0000, N, 1);
    capture;
    checks++; if (pos_cap !== 17'h01E14) begin failures++; $display("FAIL midsop_pos: got %h need 01e14", pos_cap); end
    checks++; if (pulses - p0 !== 1) begin failures++; $display("FAIL midsop_count: got %0d need 1", pulses - p0); end
    checks++; if (err_cap !== 1'b0) begin failures++; $display("FAIL midsop_err: got %b need 0", err_cap); end
  endtask

  initial begin
    test_reset;
    test_single_pixel;
    test_rectangle;
    test_no_match;
    test_threshold;
    test_bad_packets;
    test_reset_interrupt;
    test_sop_midframe;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
